// File: rtl/bpf_forwarder.sv
`timescale 1ns/1ps
// Forwarder-side reader of the BPF packet memory: reads an accepted packet in
// 64-bit beats, streams it on AXI-Stream with backpressure, then releases the buffer.
module bpf_forwarder #(
   parameter int PACKET_ADDR_WIDTH = 10,
   parameter int LEN_WIDTH         = PACKET_ADDR_WIDTH + 3
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         ready_for_forwarder,
   input  logic [LEN_WIDTH-1:0]         fwd_byte_len,
   output logic [PACKET_ADDR_WIDTH-1:0] forwarder_rd_addr,
   output logic                         forwarder_rd_en,
   input  logic [63:0]                  forwarder_rd_data,
   output logic                         forwarder_done,
   output logic [63:0]                  m_axis_tdata,
   output logic [7:0]                   m_axis_tkeep,
   output logic                         m_axis_tvalid,
   output logic                         m_axis_tlast,
   input  logic                         m_axis_tready
);

   localparam int BEAT_WIDTH = PACKET_ADDR_WIDTH + 1;
   localparam logic [LEN_WIDTH-1:0] MAX_LEN = LEN_WIDTH'(1) << (PACKET_ADDR_WIDTH + 2);

   localparam logic [1:0] ST_IDLE     = 2'd0;
   localparam logic [1:0] ST_STREAM   = 2'd1;
   localparam logic [1:0] ST_DONE     = 2'd2;
   localparam logic [1:0] ST_COOLDOWN = 2'd3;

   logic [1:0]                   state_q, state_d;
   logic [LEN_WIDTH-1:0]         len_q, len_d;
   logic [BEAT_WIDTH-1:0]        beats_q, beats_d;
   logic [BEAT_WIDTH-1:0]        issued_q, issued_d;
   logic [BEAT_WIDTH-1:0]        popped_q, popped_d;
   logic [PACKET_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                         inflight_q, inflight_d;
   logic [63:0]                  fifo_q [3];
   logic [63:0]                  fifo_d [3];
   logic [1:0]                   wr_ptr_q, wr_ptr_d;
   logic [1:0]                   rd_ptr_q, rd_ptr_d;
   logic [1:0]                   count_q, count_d;

   logic [LEN_WIDTH-1:0]  len_clamped;
   logic [BEAT_WIDTH-1:0] beats_calc;
   logic [7:0]            last_keep;
   logic                  is_last;
   logic                  push;
   logic                  pop;
   logic                  can_issue;

   assign len_clamped = (fwd_byte_len > MAX_LEN) ? MAX_LEN : fwd_byte_len;
   assign beats_calc  = BEAT_WIDTH'(len_clamped[LEN_WIDTH-1:3]) + BEAT_WIDTH'(|len_clamped[2:0]);
   assign last_keep   = (len_q[2:0] == 3'd0) ? 8'hFF : ~(8'hFF << len_q[2:0]);

   // The FIFO head is the beat with index popped_q, so last-beat framing comes from that count.
   assign m_axis_tvalid = (count_q != 2'd0);
   assign is_last       = (popped_q == beats_q - BEAT_WIDTH'(1));
   assign pop           = m_axis_tvalid & m_axis_tready;
   assign push          = inflight_q;
   assign m_axis_tdata  = m_axis_tvalid ? fifo_q[rd_ptr_q] : 64'd0;
   assign m_axis_tkeep  = m_axis_tvalid ? (is_last ? last_keep : 8'hFF) : 8'h00;
   assign m_axis_tlast  = m_axis_tvalid & is_last;

   // Reads in flight are counted against the FIFO so returning data always has a slot.
   assign can_issue = (state_q == ST_STREAM) && (issued_q < beats_q) &&
                      (({1'b0, count_q} + {2'b00, inflight_q}) < 3'd3);

   assign forwarder_rd_en   = can_issue;
   assign forwarder_rd_addr = addr_q;
   assign forwarder_done    = (state_q == ST_DONE);

   always_comb begin
      state_d    = state_q;
      len_d      = len_q;
      beats_d    = beats_q;
      issued_d   = issued_q;
      popped_d   = popped_q;
      addr_d     = addr_q;
      inflight_d = can_issue;
      fifo_d     = fifo_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q;

      case (state_q)
         ST_IDLE: begin
            if (ready_for_forwarder) begin
               len_d    = len_clamped;
               beats_d  = beats_calc;
               issued_d = '0;
               popped_d = '0;
               addr_d   = '0;
               state_d  = (len_clamped == '0) ? ST_DONE : ST_STREAM;
            end
         end
         ST_STREAM: begin
            if (can_issue) begin
               addr_d   = addr_q + PACKET_ADDR_WIDTH'(2);
               issued_d = issued_q + BEAT_WIDTH'(1);
            end
            if (pop) begin
               popped_d = popped_q + BEAT_WIDTH'(1);
               if (is_last) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_COOLDOWN;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      if (push) begin
         fifo_d[wr_ptr_q] = forwarder_rd_data;
         wr_ptr_d = (wr_ptr_q == 2'd2) ? 2'd0 : wr_ptr_q + 2'd1;
      end
      if (pop) begin
         rd_ptr_d = (rd_ptr_q == 2'd2) ? 2'd0 : rd_ptr_q + 2'd1;
      end
      case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= ST_IDLE;
         len_q      <= '0;
         beats_q    <= '0;
         issued_q   <= '0;
         popped_q   <= '0;
         addr_q     <= '0;
         inflight_q <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            fifo_q[i] <= 64'd0;
         end
         wr_ptr_q   <= 2'd0;
         rd_ptr_q   <= 2'd0;
         count_q    <= 2'd0;
      end else begin
         state_q    <= state_d;
         len_q      <= len_d;
         beats_q    <= beats_d;
         issued_q   <= issued_d;
         popped_q   <= popped_d;
         addr_q     <= addr_d;
         inflight_q <= inflight_d;
         for (int i = 0; i < 3; i++) begin
            fifo_q[i] <= fifo_d[i];
         end
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
      end
   end

endmodule

// File: tb/tb_bpf_forwarder.sv
`timescale 1ns/1ps
// Self-checking bench for bpf_forwarder: a packet-memory model answers reads and a
// per-packet scoreboard derives every beat from the length rules and memory contents.
module tb_bpf_forwarder;

   localparam int AW = 10;
   localparam int LW = AW + 3;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ready_for_forwarder = 1'b0;
   logic [LW-1:0] fwd_byte_len = '0;
   logic [AW-1:0] forwarder_rd_addr;
   logic          forwarder_rd_en;
   logic [63:0]   forwarder_rd_data;
   logic          forwarder_done;
   logic [63:0]   m_axis_tdata;
   logic [7:0]    m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic          m_axis_tready = 1'b0;

   always #5 clk = ~clk;

   bpf_forwarder #(.PACKET_ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .ready_for_forwarder (ready_for_forwarder),
      .fwd_byte_len        (fwd_byte_len),
      .forwarder_rd_addr   (forwarder_rd_addr),
      .forwarder_rd_en     (forwarder_rd_en),
      .forwarder_rd_data   (forwarder_rd_data),
      .forwarder_done      (forwarder_done),
      .m_axis_tdata        (m_axis_tdata),
      .m_axis_tkeep        (m_axis_tkeep),
      .m_axis_tvalid       (m_axis_tvalid),
      .m_axis_tlast        (m_axis_tlast),
      .m_axis_tready       (m_axis_tready)
   );

   // Packet memory: a read of word address a returns words a (low) and a+1 (high) next cycle.
   logic [31:0] mem [1024];
   logic [AW-1:0] rd_addr_plus1;
   assign rd_addr_plus1 = forwarder_rd_addr + AW'(1);

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         forwarder_rd_data <= 64'd0;
      end else if (forwarder_rd_en) begin
         forwarder_rd_data <= {mem[rd_addr_plus1], mem[forwarder_rd_addr]};
      end
   end

   typedef struct {
      int         len;
      int         pct;
      int         exp_beats;
      logic [7:0] exp_last_keep;
   } vec_t;

   vec_t vecs[$];

   int tests = 0;
   int fails = 0;

   int cyc, issued, hs_cnt, first_rd, first_valid, done_cyc, done_cnt, last_hs;
   int total_beats = 0, total_last = 0, total_done = 0;
   logic        prev_stall = 1'b0;
   logic [63:0] prev_data;
   logic [7:0]  prev_keep;
   logic        prev_last;
   logic [63:0] cap_data[$];
   logic [7:0]  cap_keep[$];
   logic        cap_last[$];

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic rdy, input logic [LW-1:0] len, input int pct);
      @(negedge clk);
      ready_for_forwarder = rdy;
      fwd_byte_len        = len;
      m_axis_tready       = ($urandom_range(0, 99) < pct);
   endtask

   task automatic clear_pkt();
      cap_data.delete();
      cap_keep.delete();
      cap_last.delete();
      cyc = 0; issued = 0; hs_cnt = 0;
      first_rd = -1; first_valid = -1; done_cyc = -1; done_cnt = 0; last_hs = -1;
   endtask

   // One cycle: drive inputs at the falling edge, then observe what the next rising edge will act on.
   task automatic tick(input logic rdy, input logic [LW-1:0] len, input int pct);
      applyStimulus(rdy, len, pct);
      #1;
      if (prev_stall) begin
         checkOutput("stall_valid", 64'(m_axis_tvalid), 64'd1);
         checkOutput("stall_data", m_axis_tdata, prev_data);
         checkOutput("stall_keep", 64'(m_axis_tkeep), 64'(prev_keep));
         checkOutput("stall_last", 64'(m_axis_tlast), 64'(prev_last));
      end
      if (forwarder_rd_en) begin
         if (first_rd < 0) first_rd = cyc;
         checkOutput("rd_addr", 64'(forwarder_rd_addr), 64'((2 * issued) % 1024));
         issued++;
         checkOutput("outstanding_le_3", 64'(issued - hs_cnt <= 3), 64'd1);
      end
      if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
      if (m_axis_tvalid && m_axis_tready) begin
         cap_data.push_back(m_axis_tdata);
         cap_keep.push_back(m_axis_tkeep);
         cap_last.push_back(m_axis_tlast);
         hs_cnt++;
         last_hs = cyc;
         total_beats++;
         if (m_axis_tlast) total_last++;
      end
      if (forwarder_done) begin
         done_cnt++;
         total_done++;
         if (done_cyc < 0) done_cyc = cyc;
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      prev_data  = m_axis_tdata;
      prev_keep  = m_axis_tkeep;
      prev_last  = m_axis_tlast;
      cyc++;
   endtask

   // Runs one packet to completion (including the cooldown cycle) and scores it against the model.
   task automatic run_packet(input int len, input int pct, output int got_beats, output logic [7:0] got_keep);
      int lc, nb, lr, budget, a;
      logic [63:0] ed;
      logic [7:0]  ek;
      lc = (len > 4096) ? 4096 : len;
      nb = (lc + 7) / 8;
      lr = lc % 8;
      clear_pkt();
      budget = 40 + 20 * nb;
      tick(1'b1, LW'(len), pct);
      while (done_cnt == 0 && cyc < budget) tick(1'b1, LW'(len), pct);
      if (done_cnt == 0) begin
         checkOutput("done_timeout", 64'd0, 64'd1);
      end else begin
         tick(1'b0, '0, pct);
         checkOutput("single_done", 64'(done_cnt), 64'd1);
      end
      checkOutput("beat_count", 64'(cap_data.size()), 64'(nb));
      for (int k = 0; k < nb && k < cap_data.size(); k++) begin
         a  = (2 * k) % 1024;
         ed = {mem[(a + 1) % 1024], mem[a]};
         ek = (k == nb - 1 && lr != 0) ? 8'((1 << lr) - 1) : 8'hFF;
         checkOutput("beat_data", cap_data[k], ed);
         checkOutput("beat_keep", 64'(cap_keep[k]), 64'(ek));
         checkOutput("beat_last", 64'(cap_last[k]), 64'(k == nb - 1));
      end
      if (nb == 0) begin
         checkOutput("zero_no_rd", 64'(issued), 64'd0);
         checkOutput("zero_no_valid", 64'(first_valid < 0), 64'd1);
         checkOutput("zero_done_cycle", 64'(done_cyc), 64'd1);
      end else begin
         checkOutput("first_rd_cycle", 64'(first_rd), 64'd1);
         checkOutput("first_valid_cycle", 64'(first_valid), 64'd3);
         checkOutput("done_after_last", 64'(done_cyc), 64'(last_hs + 1));
         if (pct >= 100) checkOutput("done_cycle_full_rate", 64'(done_cyc), 64'(nb + 3));
      end
      got_beats = cap_data.size();
      got_keep  = (cap_keep.size() > 0) ? cap_keep[cap_keep.size() - 1] : 8'h00;
   endtask

   task automatic check_outputs_zero(input string tag);
      checkOutput({tag, "_rd_en"}, 64'(forwarder_rd_en), 64'd0);
      checkOutput({tag, "_rd_addr"}, 64'(forwarder_rd_addr), 64'd0);
      checkOutput({tag, "_done"}, 64'(forwarder_done), 64'd0);
      checkOutput({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
      checkOutput({tag, "_tdata"}, m_axis_tdata, 64'd0);
      checkOutput({tag, "_tkeep"}, 64'(m_axis_tkeep), 64'd0);
      checkOutput({tag, "_tlast"}, 64'(m_axis_tlast), 64'd0);
   endtask

   initial begin
      int gb;
      logic [7:0] gk;
      int b0, l0, d0;

      for (int i = 0; i < 1024; i++) mem[i] = $urandom;

      vecs.push_back('{20,   100, 3,   8'h0F});
      vecs.push_back('{16,   100, 2,   8'hFF});
      vecs.push_back('{0,    100, 0,   8'h00});
      vecs.push_back('{1,    100, 1,   8'h01});
      vecs.push_back('{23,   60,  3,   8'h7F});
      vecs.push_back('{4096, 50,  512, 8'hFF});
      vecs.push_back('{5000, 100, 512, 8'hFF});
      vecs.push_back('{4095, 70,  512, 8'h7F});
      vecs.push_back('{8191, 100, 512, 8'hFF});

      repeat (2) @(negedge clk);
      #1;
      check_outputs_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      foreach (vecs[i]) begin
         run_packet(vecs[i].len, vecs[i].pct, gb, gk);
         checkOutput("tbl_beats", 64'(gb), 64'(vecs[i].exp_beats));
         if (vecs[i].exp_beats > 0) checkOutput("tbl_last_keep", 64'(gk), 64'(vecs[i].exp_last_keep));
      end

      b0 = total_beats; l0 = total_last; d0 = total_done;
      run_packet(24, 100, gb, gk);
      run_packet(24, 100, gb, gk);
      checkOutput("b2b_beats", 64'(total_beats - b0), 64'd6);
      checkOutput("b2b_tlast", 64'(total_last - l0), 64'd2);
      checkOutput("b2b_done", 64'(total_done - d0), 64'd2);

      clear_pkt();
      tick(1'b1, LW'(80), 100);
      while (hs_cnt < 5 && cyc < 100) tick(1'b1, LW'(80), 100);
      checkOutput("rst_reached_beat5", 64'(hs_cnt), 64'd5);
      @(negedge clk);
      rst = 1'b0;
      ready_for_forwarder = 1'b0;
      #1;
      check_outputs_zero("midrst");
      repeat (3) begin
         @(negedge clk);
         #1;
         checkOutput("midrst_no_done", 64'(forwarder_done), 64'd0);
      end
      @(negedge clk);
      rst = 1'b1;
      prev_stall = 1'b0;
      run_packet(40, 100, gb, gk);

      for (int r = 0; r < 6; r++) begin
         run_packet(int'($urandom_range(0, 4200)), int'($urandom_range(30, 100)), gb, gk);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/bpf_forwarder.md
# bpf_forwarder

Reader at the forwarder end of the BPF packet-memory interface. Once the packet memory signals an accepted packet through `ready_for_forwarder`, this block reads the packet out in 64-bit beats. It streams the beats on an AXI-Stream master port under backpressure, then returns the buffer with a one-cycle `forwarder_done` pulse. It sits between `bpfvm` and the downstream egress logic.

## Interface
- `PACKET_ADDR_WIDTH`, 10: packet memory word address width, in 32-bit word units.
- `LEN_WIDTH`, `PACKET_ADDR_WIDTH+3`: width of the packet byte-length input.
- `clk` in 1: sole clock; all logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `ready_for_forwarder` in 1: packet memory holds an accepted packet for this block.
- `fwd_byte_len` in `LEN_WIDTH`: packet length in bytes; valid while `ready_for_forwarder`=1.
- `forwarder_rd_addr` out `PACKET_ADDR_WIDTH`: 32-bit word address. Each read returns words `addr` and `addr+1`.
- `forwarder_rd_en` out 1: read strobe.
- `forwarder_rd_data` in 64: read data, valid exactly one cycle after `forwarder_rd_en`.
- `forwarder_done` out 1: one-cycle pulse that releases the buffer.
- `m_axis_tdata` out 64: `forwarder_rd_data` passed through unchanged.
- `m_axis_tkeep` out 8: byte enables, low bytes first.
- `m_axis_tvalid`, `m_axis_tlast` out 1: stream valid / last beat.
- `m_axis_tready` in 1: downstream ready.

## Operation
- FSM states: IDLE, STREAM, DONE, COOLDOWN.
- IDLE:
  - Waits for `ready_for_forwarder`=1.
  - Latches `len = min(fwd_byte_len, 2^(PACKET_ADDR_WIDTH+2))`.
  - Computes `beats = ceil(len/8)` and resets the read address to 0.
  - If `len`=0, goes to DONE (no beats). Otherwise goes to STREAM.
- STREAM, read side:
  - Asserts `forwarder_rd_en` when `beats_issued < beats` and `fifo_count + inflight < 3`.
  - The 3-entry output FIFO guarantees full throughput.
  - Address starts at 0 and advances by 2 per issued read; `beats_issued` increments.
- STREAM, data capture: data arriving on `forwarder_rd_data` is pushed into the FIFO in the cycle it is valid. The FIFO never overflows, by the issue rule.
- STREAM, output side:
  - The FIFO head drives `m_axis_*`.
  - A pop occurs when `tvalid && tready`. Push and pop in the same cycle keep the count unchanged.
  - `tlast`=1 only on beat index `beats-1`.
  - `tkeep` = 0xFF except on the last beat, where it is `(1<<(len%8))-1`, or 0xFF if `len%8`=0.
- STREAM exit: goes to DONE on the handshake of the last beat.
- DONE: asserts `forwarder_done` for exactly one cycle, then goes to COOLDOWN.
- COOLDOWN:
  - Lasts one cycle and ignores `ready_for_forwarder`, which packet memory lowers within one cycle of done.
  - Then returns to IDLE, where the next (ping-pong) buffer may be taken immediately.
- AXI rules:
  - `tvalid` never drops before its handshake.
  - `tdata`, `tkeep` and `tlast` are stable while `tvalid`=1 and `tready`=0.
  - `tready` may toggle arbitrarily; no beat is lost or duplicated.
- Reset (`rst`=0), at any time including mid-stream:
  - FSM goes to IDLE and the FIFO and all counters clear.
  - All outputs are 0, including `forwarder_rd_addr`.
  - No done pulse is emitted; a buffer held at reset stays with packet memory.
- Counters are sized so the maximum length (4096 bytes, 512 beats at width 10) never wraps. Lengths above the maximum are clamped, never wrapped.

## Timing
- Cycle 0: `ready_for_forwarder` sampled in IDLE.
- Cycle 1: first `forwarder_rd_en` (addr 0).
- Cycle 2: data captured.
- Cycle 3: first `m_axis_tvalid`=1.
- Throughput: with `tready` held at 1, one beat per cycle with no bubbles.
- Done pulse: `forwarder_done` is high in the cycle after the last-beat handshake.
- Minimum spacing: new ready sampling is possible 2 cycles after the done pulse.
- Zero-length packet: done pulse in cycle 1.
- `tready` low: reads stop once `fifo_count + inflight` = 3; reads already in flight are absorbed by the FIFO.

## Test plan
- 20-byte packet, `tready`=1:
  - Reads at addr 0, 2, 4 on consecutive cycles 1-3.
  - 3 beats with `tkeep` FF, FF, 0F; `tlast` on beat 3.
  - `forwarder_done` exactly one cycle after the beat-3 handshake.
- 16-byte packet: 2 beats, last `tkeep`=FF with `tlast`.
- 4096-byte packet with random `tready` (50%):
  - 512 beats in order, each equal to memory contents.
  - Never more than 3 reads outstanding beyond the FIFO.
  - Stable data while stalled.
- `fwd_byte_len`=0: no `rd_en`, no `tvalid`; `forwarder_done` pulse in cycle 1.
- Reset asserted mid-stream on beat 5 of 10:
  - Outputs 0 immediately.
  - No done pulse.
  - After release, the next packet streams correctly from addr 0.
- Two back-to-back 24-byte packets with `ready_for_forwarder` re-asserted right after COOLDOWN:
  - 6 beats total, two `tlast` and two done pulses.
  - No beat mixing between packets.
